// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    // Default geometry and thresholds used when the FIFO is instantiated bare.
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_AFULL_TH  = 12;
    localparam int DEF_AEMPTY_TH = 4;

    // Ceiling log2, usable in constant expressions (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and status control for sync_fifo_param: accept
// decisions, wrap-bit pointers, count, threshold flags and sticky errors.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AFULL_TH  = DEF_AFULL_TH,
    parameter int AEMPTY_TH = DEF_AEMPTY_TH,
    parameter int AW        = clog2(DEF_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic          clr_err,
    output logic          wr_acc,
    output logic          rd_acc,
    output logic [AW-1:0] wr_idx,
    output logic [AW-1:0] rd_idx,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW:0] PTR_ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] DEPTH_CNT  = DEPTH[AW:0];
    localparam logic [AW:0] AFULL_CNT  = AFULL_TH[AW:0];
    localparam logic [AW:0] AEMPTY_CNT = AEMPTY_TH[AW:0];

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        wr_room;
    logic        ovf_set;
    logic        unf_set;

    // Occupancy is the modular pointer difference; the extra wrap bit makes
    // full (DEPTH) and empty (0) distinguishable without extra state.
    assign count        = wr_ptr - rd_ptr;
    assign full         = (count == DEPTH_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_CNT);
    assign almost_empty = (count <= AEMPTY_CNT);

    // A read in the same cycle frees the slot a write into a full FIFO needs.
    // Flush masks both requests so they neither move pointers nor flag errors.
    assign wr_room = ~full | rd_en;
    assign wr_acc  = ~flush & wr_en & wr_room;
    assign rd_acc  = ~flush & rd_en & ~empty;
    assign ovf_set = ~flush & wr_en & ~wr_room;
    assign unf_set = ~flush & rd_en & empty;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    // Advance pointers on accepted operations; flush returns both to zero.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values and simulation matches the synthesised hardware.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Sticky error flags: a new error wins over a coincident clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set)      overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
            if (unf_set)      underflow <= 1'b1;
            else if (clr_err) underflow <= 1'b0;
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: RAM array plus registered read port,
// with pointer/flag control delegated to fifo_ptr_ctrl.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AFULL_TH  = DEF_AFULL_TH,
    parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [clog2(DEPTH):0]  count,
    output logic                   overflow,
    output logic                   underflow,
    input  logic                   clr_err
);

    localparam int AW = clog2(DEPTH);

    // Reject geometries the pointer arithmetic cannot represent.
    if (DATA_W < 1) begin : g_bad_width
        $fatal(1, "sync_fifo_param: DATA_W must be >= 1");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "sync_fifo_param: DEPTH must be a power of two >= 4");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
        $fatal(1, "sync_fifo_param: AFULL_TH must be in 1..DEPTH");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
        $fatal(1, "sync_fifo_param: AEMPTY_TH must be in 0..DEPTH-1");
    end

    logic              wr_acc;
    logic              rd_acc;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;
    logic [DATA_W-1:0] mem [DEPTH];

    fifo_ptr_ctrl #(
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH),
        .AW        (AW)
    ) u_ptr_ctrl (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .clr_err      (clr_err),
        .wr_acc       (wr_acc),
        .rd_acc       (rd_acc),
        .wr_idx       (wr_idx),
        .rd_idx       (rd_idx),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Store accepted write data.
    // NOTE: the RAM has no reset so it maps onto plain memory; stale contents
    // are never observable because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_idx] <= wr_data;
    end

    // Registered read port: a same-slot write at full returns the old word
    // because the RAM update lands after this edge samples it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (flush) begin
            rd_valid <= 1'b0;
        end else if (rd_acc) begin
            rd_data  <= mem[rd_idx];
            rd_valid <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule
